// File: rtl/sensor_poll_scheduler.sv
// Sequences crossbar commands: arbitrates host 'T'/'D' bytes against a periodic
// auto-poll that alternates 'T' and 'D', issuing one transaction at a time.
module sensor_poll_scheduler #(
    parameter int unsigned POLL_PERIOD    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_cmd,
    input  logic       host_cmd_valid,
    input  logic       auto_en,
    output logic [7:0] xbar_cmd,
    output logic       xbar_cmd_valid,
    input  logic       xbar_ready_to_act,
    input  logic       xbar_done,
    output logic       busy,
    output logic       last_src,
    output logic       timeout_err,
    output logic       reject,
    output logic [7:0] overrun_cnt
);
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned TICK_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CMD_W-1:0]  CMD_T     = 8'h54;
    localparam logic [CMD_W-1:0]  CMD_D     = 8'h44;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CMD_W-1:0]   cmd_nxt;
    logic               valid_nxt, terr_nxt, src_nxt;
    logic               host_take, auto_take;

    logic               host_pending, auto_pending, auto_toggle;
    logic [CMD_W-1:0]   host_byte;
    logic [TICK_W-1:0]  tick_cnt;
    logic               tick;
    logic               host_ok;

    assign tick    = auto_en && (tick_cnt == TICK_LAST);
    assign host_ok = (host_cmd == CMD_T) || (host_cmd == CMD_D);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            xbar_cmd       <= '0;
            xbar_cmd_valid <= 1'b0;
            timeout_err    <= 1'b0;
            last_src       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            xbar_cmd       <= cmd_nxt;
            xbar_cmd_valid <= valid_nxt;
            timeout_err    <= terr_nxt;
            last_src       <= src_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

    // Next-state and output decode; cnt times both WAIT_DONE and GAP
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cmd_nxt   = xbar_cmd;
        valid_nxt = 1'b0;
        terr_nxt  = 1'b0;
        src_nxt   = last_src;
        host_take = 1'b0;
        auto_take = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (host_pending) begin
                    host_take = 1'b1;
                    cmd_nxt   = host_byte;
                    src_nxt   = 1'b0;
                    state_nxt = ISSUE;
                end else if (auto_pending) begin
                    auto_take = 1'b1;
                    cmd_nxt   = auto_toggle ? CMD_D : CMD_T;
                    src_nxt   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (xbar_ready_to_act) begin
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (xbar_done || (cnt == TO_LAST)) begin
                    terr_nxt  = !xbar_done;
                    cnt_nxt   = '0;
                    cmd_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture: one host slot, one auto slot, tick timer and overrun count
    always_ff @(posedge clk) begin
        if (!rst) begin
            host_pending <= 1'b0;
            host_byte    <= '0;
            reject       <= 1'b0;
            tick_cnt     <= '0;
            auto_pending <= 1'b0;
            auto_toggle  <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            reject <= 1'b0;
            if (host_take) begin
                host_pending <= 1'b0;
            end
            if (host_cmd_valid) begin
                if (host_ok && !host_pending) begin
                    host_byte    <= host_cmd;
                    host_pending <= 1'b1;
                end else begin
                    reject <= 1'b1;
                end
            end

            if (!auto_en || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            // A tick landing on the cycle the old request is taken is not an overrun
            if (tick) begin
                auto_pending <= 1'b1;
                if (auto_pending && !auto_take && (overrun_cnt != 8'hFF)) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (auto_take) begin
                auto_pending <= 1'b0;
            end
            if (auto_take) begin
                auto_toggle <= ~auto_toggle;
            end
        end
    end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler with short poll/timeout/gap periods.
module tb_sensor_poll_scheduler;
    localparam int unsigned POLL = 100;
    localparam int unsigned TO   = 50;
    localparam int unsigned GAPC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_cmd;
    logic       host_cmd_valid;
    logic       auto_en;
    logic [7:0] xbar_cmd;
    logic       xbar_cmd_valid;
    logic       ready;
    logic       done;
    logic       busy;
    logic       last_src;
    logic       timeout_err;
    logic       reject;
    logic [7:0] overrun_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sensor_poll_scheduler #(
        .POLL_PERIOD(POLL), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk), .rst(rst),
        .host_cmd(host_cmd), .host_cmd_valid(host_cmd_valid), .auto_en(auto_en),
        .xbar_cmd(xbar_cmd), .xbar_cmd_valid(xbar_cmd_valid),
        .xbar_ready_to_act(ready), .xbar_done(done),
        .busy(busy), .last_src(last_src), .timeout_err(timeout_err),
        .reject(reject), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; host_cmd_valid = 1'b0; host_cmd = 8'h00;
        auto_en = 1'b0; done = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 250 && !ok; i++) begin
            step();
            if (xbar_cmd_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // done is sampled lat edges after the strobe edge
    task automatic finish_txn(input int lat);
        for (int i = 0; i < lat - 1; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        ready = 1'b1;
        apply_reset();
        rst = 1'b0;
        step();
        checks++;
        if (xbar_cmd !== 8'h00 || overrun_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_bytes cmd=%h overrun=%h required 00/00", xbar_cmd, overrun_cnt);
        end
        checks++;
        if ({xbar_cmd_valid, busy, last_src, timeout_err, reject} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags v/b/s/t/r=%b required 00000",
                     {xbar_cmd_valid, busy, last_src, timeout_err, reject});
        end
        rst = 1'b1;
    endtask

    task automatic test_host_issue();
        int strobes = 0;
        int errs = 0;
        auto_en = 1'b0; ready = 1'b1;
        host_cmd = 8'h54; host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL host_capture busy=%b required 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || xbar_cmd !== 8'h54 || xbar_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL host_issue busy=%b cmd=%h valid=%b required 1/54/0", busy, xbar_cmd, xbar_cmd_valid);
        end
        step();
        checks++;
        if (xbar_cmd_valid !== 1'b1 || xbar_cmd !== 8'h54 || last_src !== 1'b0) begin
            failures++;
            $display("FAIL host_strobe valid=%b cmd=%h src=%b required 1/54/0", xbar_cmd_valid, xbar_cmd, last_src);
        end
        for (int i = 0; i < 19; i++) begin
            step();
            if (xbar_cmd_valid === 1'b1) strobes++;
            if (timeout_err === 1'b1) errs++;
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (xbar_cmd !== 8'h00 || busy !== 1'b1) begin
            failures++; $display("FAIL gap_entry cmd=%h busy=%b required 00/1", xbar_cmd, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (timeout_err === 1'b1) errs++;
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL gap_busy[%0d] busy=%b required 1", i, busy);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL busy_fall busy=%b required 0", busy);
        end
        checks++;
        if (strobes != 0 || errs != 0) begin
            failures++; $display("FAIL host_extra strobes=%0d errs=%0d required 0/0", strobes, errs);
        end
    endtask

    task automatic test_reject();
        host_cmd = 8'h58; host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        checks++;
        if (reject !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL reject_pulse reject=%b busy=%b required 1/0", reject, busy);
        end
        step();
        checks++;
        if (reject !== 1'b0) begin
            failures++; $display("FAIL reject_width reject=%b required 0", reject);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (busy !== 1'b0 || xbar_cmd !== 8'h00) begin
            failures++; $display("FAIL reject_noissue busy=%b cmd=%h required 0/00", busy, xbar_cmd);
        end
    endtask

    task automatic test_pending_reject();
        int strobes = 0;
        host_cmd = 8'h54; host_cmd_valid = 1'b1;
        step();
        host_cmd = 8'h44;
        step();
        host_cmd_valid = 1'b0;
        checks++;
        if (reject !== 1'b1 || xbar_cmd !== 8'h54) begin
            failures++; $display("FAIL pending_reject reject=%b cmd=%h required 1/54", reject, xbar_cmd);
        end
        step();
        finish_txn(3);
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            if (xbar_cmd_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            failures++; $display("FAIL dropped_issued strobes=%0d required 0", strobes);
        end
    endtask

    task automatic test_auto_poll();
        logic [7:0] exp_cmd [3];
        int t0;
        bit ok;
        exp_cmd[0] = 8'h54; exp_cmd[1] = 8'h44; exp_cmd[2] = 8'h54;
        apply_reset();
        ready = 1'b1; auto_en = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(ok);
            checks++;
            if (!ok || cyc != t0 + 102 + 100 * k) begin
                failures++;
                $display("FAIL auto_timing[%0d] ok=%b cycle=%0d required %0d", k, ok, cyc - t0, 102 + 100 * k);
            end
            checks++;
            if (xbar_cmd !== exp_cmd[k] || last_src !== 1'b1) begin
                failures++;
                $display("FAIL auto_cmd[%0d] cmd=%h src=%b required %h/1", k, xbar_cmd, last_src, exp_cmd[k]);
            end
            finish_txn(10);
        end
        auto_en = 1'b0;
        wait_idle();
        checks++;
        if (overrun_cnt !== 8'd0) begin
            failures++; $display("FAIL auto_overrun cnt=%0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_priority();
        int d;
        bit ok;
        apply_reset();
        ready = 1'b1; auto_en = 1'b1;
        for (int i = 0; i < 99; i++) step();
        host_cmd = 8'h44; host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        auto_en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || xbar_cmd !== 8'h44 || last_src !== 1'b0) begin
            failures++;
            $display("FAIL prio_host busy=%b cmd=%h src=%b required 1/44/0", busy, xbar_cmd, last_src);
        end
        step();
        finish_txn(10);
        d = cyc;
        wait_strobe(ok);
        checks++;
        if (!ok || cyc != d + 6 || xbar_cmd !== 8'h54 || last_src !== 1'b1) begin
            failures++;
            $display("FAIL prio_auto ok=%b delay=%0d cmd=%h src=%b required 1/6/54/1",
                     ok, cyc - d, xbar_cmd, last_src);
        end
        finish_txn(3);
        wait_idle();
    endtask

    task automatic test_timeout();
        int errs = 0;
        int t;
        bit ok;
        ready = 1'b1;
        host_cmd = 8'h54; host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 49; i++) begin
            step();
            if (i == 0) begin
                host_cmd = 8'h44; host_cmd_valid = 1'b1;
            end else begin
                host_cmd_valid = 1'b0;
            end
            if (timeout_err === 1'b1) errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++; $display("FAIL timeout_early pulses=%0d required 0", errs);
        end
        step();
        t = cyc;
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++; $display("FAIL timeout_pulse err=%b required 1", timeout_err);
        end
        step();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++; $display("FAIL timeout_width err=%b required 0", timeout_err);
        end
        wait_strobe(ok);
        checks++;
        if (!ok || cyc != t + 6 || xbar_cmd !== 8'h44 || last_src !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next ok=%b delay=%0d cmd=%h src=%b required 1/6/44/0",
                     ok, cyc - t, xbar_cmd, last_src);
        end
        finish_txn(5);
        wait_idle();
    endtask

    task automatic test_ready_and_reset();
        int strobes = 0;
        int errs = 0;
        ready = 1'b0;
        host_cmd = 8'h54; host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 30; i++) begin
            step();
            if (xbar_cmd_valid === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0 || busy !== 1'b1 || xbar_cmd !== 8'h54) begin
            failures++;
            $display("FAIL ready_hold strobes=%0d busy=%b cmd=%h required 0/1/54", strobes, busy, xbar_cmd);
        end
        ready = 1'b1;
        step();
        checks++;
        if (xbar_cmd_valid !== 1'b1) begin
            failures++; $display("FAIL ready_strobe valid=%b required 1", xbar_cmd_valid);
        end
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (xbar_cmd !== 8'h00 || {xbar_cmd_valid, busy, last_src, timeout_err, reject} !== 5'b0) begin
            failures++;
            $display("FAIL midreset cmd=%h v/b/s/t/r=%b required 00/00000",
                     xbar_cmd, {xbar_cmd_valid, busy, last_src, timeout_err, reject});
        end
        for (int i = 0; i < 60; i++) begin
            step();
            if (timeout_err === 1'b1 || busy === 1'b1) errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++; $display("FAIL midreset_stale events=%0d required 0", errs);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        ready = 1'b0; auto_en = 1'b1;
        for (int i = 0; i < 299; i++) step();
        checks++;
        if (overrun_cnt !== 8'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL overrun_pre cnt=%0d busy=%b required 0/1", overrun_cnt, busy);
        end
        step();
        checks++;
        if (overrun_cnt !== 8'd1) begin
            failures++; $display("FAIL overrun_inc cnt=%0d required 1", overrun_cnt);
        end
        apply_reset();
        ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_host_issue();
        test_reject();
        test_pending_reject();
        test_auto_poll();
        test_priority();
        test_timeout();
        test_ready_and_reset();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
